// File: rtl/y_demux_pkg.sv
// Shared constants and types for the 1-to-2 stream demultiplexer.
package y_demux_pkg;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 8;

    typedef logic [CNT_W-1:0] cnt_t;

endpackage

// File: rtl/y_fifo2.sv
// Two-entry FIFO with a one-hot-free EMPTY/ONE/TWO state machine and 1-bit pointers.
// Push is ignored when full and pop is ignored when empty.
module y_fifo2
    import y_demux_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wdata,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t       state;
    logic         wptr;
    logic         rptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    // Qualify requests against the current occupancy.
    always_comb begin
        do_push = push && (state != TWO);
        do_pop  = pop  && (state != EMPTY);
    end

    // Occupancy state, pointers and storage; storage is cleared so rdata is never X.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
            wptr  <= 1'b0;
            rptr  <= 1'b0;
            mem   <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wptr] <= wdata;
                wptr      <= ~wptr;
            end
            if (do_pop) begin
                rptr <= ~rptr;
            end
            case (state)
                EMPTY: if (do_push) state <= ONE;
                ONE: begin
                    if (do_push && !do_pop)      state <= TWO;
                    else if (!do_push && do_pop) state <= EMPTY;
                end
                TWO:     if (do_pop) state <= ONE;
                default: state <= EMPTY;
            endcase
        end
    end

    // Head entry and occupancy flags straight from registered state.
    always_comb begin
        rdata = mem[rptr];
        full  = (state == TWO);
        empty = (state == EMPTY);
    end

endmodule

// File: rtl/y_demux2_stream.sv
// Registered 1-to-2 stream demultiplexer: in_sel steers each word into one of
// two independent 2-entry output buffers.
// Optional macro Y_DEMUX_CNT_EN adds per-output accepted-word counters cnt0/cnt1.
module y_demux2_stream
    import y_demux_pkg::*;
#(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_sel,
    output logic         out0_valid,
    input  logic         out0_ready,
    output logic [W-1:0] out0_data,
    output logic         out1_valid,
    input  logic         out1_ready,
    output logic [W-1:0] out1_data
`ifdef Y_DEMUX_CNT_EN
    ,
    output cnt_t         cnt0,
    output cnt_t         cnt1
`endif
);

    logic full0, full1;
    logic empty0, empty1;
    logic push0, push1;
    logic pop0, pop1;

    // Readiness depends only on the selected buffer's registered fullness.
    always_comb begin
        in_ready   = in_sel ? !full1 : !full0;
        push0      = in_valid && in_ready && !in_sel;
        push1      = in_valid && in_ready && in_sel;
        out0_valid = !empty0;
        out1_valid = !empty1;
        pop0       = out0_valid && out0_ready;
        pop1       = out1_valid && out1_ready;
    end

    y_fifo2 #(.W(W)) u_fifo0 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push0),
        .pop   (pop0),
        .wdata (in_data),
        .rdata (out0_data),
        .full  (full0),
        .empty (empty0)
    );

    y_fifo2 #(.W(W)) u_fifo1 (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push1),
        .pop   (pop1),
        .wdata (in_data),
        .rdata (out1_data),
        .full  (full1),
        .empty (empty1)
    );

`ifdef Y_DEMUX_CNT_EN
    // Count words accepted for each output; wraps naturally at 255.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else begin
            if (push0) cnt0 <= cnt0 + 1'b1;
            if (push1) cnt1 <= cnt1 + 1'b1;
        end
    end
`endif

endmodule

// File: doc/y_demux2_stream.md
Name: y_demux2_stream

Overview:
- Registered 1-to-2 stream demultiplexer; the inverse of the 2-way word mux used in the datapath.
- One input stream carries a W-bit word plus a select bit. Each word is steered to output 0 or output 1.
- Each output has its own 2-entry buffer with valid/ready handshakes on all sides.
- Sits between a producer and two independent consumers, e.g. splitting a result bus into two writeback paths.

Parameters:
- W, 2, data word width in bits (must be at least 1).
- DEPTH, 2, entries per output buffer; fixed at 2 and not to be overridden.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts the word this cycle
- in_data  input  W  word to route
- in_sel  input  1  0 routes to out0, 1 routes to out1
- out0_valid  output  1  out0 buffer non-empty
- out0_ready  input  1  consumer 0 takes the head word
- out0_data  output  W  head word of out0 buffer
- out1_valid  output  1  out1 buffer non-empty
- out1_ready  input  1  consumer 1 takes the head word
- out1_data  output  W  head word of out1 buffer

Behaviour:
- Reset (rst_n low, asynchronous):
  - both buffers empty and all pointers zero;
  - out0_valid = out1_valid = 0;
  - out0_data = out1_data = 0;
  - reset asserted mid-stream discards all buffered words.
- Handshake:
  - a transfer occurs when in_valid && in_ready at a rising clk edge;
  - outX transfers when outX_valid && outX_ready;
  - producer holds in_data and in_sel stable while in_valid is high and in_ready is low.
- in_ready = (count[in_sel] < 2):
  - combinational on in_sel and registered counts only;
  - no combinational path from out*_ready to in_ready;
  - a full buffer refuses input even if it pops in the same cycle.
- Latency: a word accepted at edge N appears at the selected output's head (outX_valid = 1) after edge N, provided its buffer was empty.
- Ordering: words routed to the same output leave in acceptance order. There is no ordering guarantee between out0 and out1.
- Per-buffer state machine (count 0/1/2):
  - EMPTY to ONE on push;
  - ONE to TWO on push without pop;
  - ONE to EMPTY on pop without push;
  - ONE stays ONE on simultaneous push and pop, with the head advancing;
  - TWO to ONE on pop;
  - push is blocked in TWO.
- Pointers: 1-bit read and write pointers that wrap 1 to 0.
- Data: outX_data always shows the entry at the read pointer. The value is don't-care when valid is 0, but it must not be X after reset.
- Idle output: a buffer not selected by in_sel is unaffected by the input, and its consumer may drain it at full rate.
- Throughput: 1 word per cycle sustained when the target consumer holds ready = 1.

Optional Feature:
- Macro Y_DEMUX_CNT_EN.
- When defined:
  - adds outputs cnt0 and cnt1 (8 bits each);
  - each counts words accepted at the input for that output;
  - each increments on the accepting edge;
  - each wraps 255 to 0;
  - both reset to 0.
- When undefined: the ports and counters do not exist, and behaviour is otherwise identical.

Decomposition:
- Package y_demux_pkg holds:
  - localparam DEPTH = 2;
  - localparam CNT_W = 8;
  - typedef cnt_t (logic [CNT_W-1:0]).
- Sub-module y_fifo2 is a W-wide 2-entry FIFO:
  - ports clk, rst_n, push, pop, wdata, rdata, full, empty;
  - instantiated twice;
  - the top level holds only routing, in_ready and the optional counters.

Test Plan:
- Reset: hold rst_n = 0, drive in_valid = 1 -> out0_valid = out1_valid = 0, data = 0, and no transfers occur. Release, then send one word -> it is routed normally.
- Routing: with W = 2, send 2'b10 with sel = 0, then 2'b01 with sel = 1, both consumers ready -> out0 shows 2'b10 one cycle after acceptance and out1 shows 2'b01 the next cycle.
- Backpressure: out0_ready = 0, send 3 words with sel = 0 -> first 2 accepted, in_ready drops for the third. Raise out0_ready -> words drain in order and the third is accepted.
- Independence: out0 full and stalled, then send sel = 1 words -> in_ready = 1 for those and out1 streams at 1 word per cycle.
- Full boundary: out1 full and out1_ready = 1 in the same cycle as a sel = 1 offer -> in_ready = 0 that cycle, and the word is accepted the next cycle.
- Counter (Y_DEMUX_CNT_EN): send 257 words with sel = 0 -> cnt0 = 1 and cnt1 = 0. Assert reset mid-run -> both counters read 0.
